// File: rtl/loop_accum_engine_if.sv
// Bundle of the loop engine's control, step and observation signals.
// The master drives commands and steps; the slave (the engine) drives loop state.
interface loop_accum_engine_if #(
    parameter int W     = 11,
    parameter int LANES = 2
);
    logic                 start;
    logic                 abort;
    logic                 hold;
    logic                 sel;
    logic [W-1:0]         cfg_n;
    logic [LANES*W-1:0]   step_a;
    logic [LANES*W-1:0]   step_b;
    logic [W-1:0]         i;
    logic [W-1:0]         n;
    logic [LANES*W-1:0]   k;
    logic                 busy;
    logic                 done;
    logic [LANES-1:0]     ovf;

    modport master (
        output start, abort, hold, sel, cfg_n, step_a, step_b,
        input  i, n, k, busy, done, ovf
    );

    modport slave (
        input  start, abort, hold, sel, cfg_n, step_a, step_b,
        output i, n, k, busy, done, ovf
    );
endinterface

// File: rtl/loop_accum_engine.sv
// Bounded-loop accumulator: a shared counter i walks 0..n while LANES accumulators
// add a selectable per-lane step each iteration, with wrap or saturate overflow.
module loop_accum_engine #(
    parameter int W        = 11,
    parameter int LANES    = 2,
    parameter int N_INIT   = 40,
    parameter int SAT      = 0,
    parameter int AUTO_RUN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    loop_accum_engine_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t       RST_STATE = (AUTO_RUN != 0) ? RUN : IDLE;
    localparam logic         RST_BUSY  = (AUTO_RUN != 0);
    localparam logic [W-1:0] N_RESET   = W'(N_INIT);

    state_t               state;
    logic                 armed;
    logic                 busy_q;
    logic                 done_q;
    logic [W-1:0]         i_q;
    logic [W-1:0]         n_q;
    logic [LANES*W-1:0]   k_q;
    logic [LANES-1:0]     ovf_q;
    logic [LANES*W-1:0]   k_next;
    logic [LANES-1:0]     carry;

    // Each lane adds one bit wider so the carry doubles as the overflow event.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [W-1:0] step;
        logic [W:0]   sum;

        assign step     = bus.sel ? bus.step_b[j*W +: W] : bus.step_a[j*W +: W];
        assign sum      = {1'b0, k_q[j*W +: W]} + {1'b0, step};
        assign carry[j] = sum[W];
        assign k_next[j*W +: W] = ((SAT != 0) && sum[W]) ? {W{1'b1}} : sum[W-1:0];
    end

    // armed swallows the first edge after reset release so no update lands on it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RST_STATE;
            busy_q <= RST_BUSY;
            done_q <= 1'b0;
            armed  <= 1'b0;
            i_q    <= '0;
            n_q    <= N_RESET;
            k_q    <= '0;
            ovf_q  <= '0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        n_q    <= bus.cfg_n;
                        i_q    <= '0;
                        k_q    <= '0;
                        ovf_q  <= '0;
                        state  <= RUN;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (!bus.hold) begin
                        if (i_q < n_q) begin
                            i_q   <= i_q + W'(1);
                            k_q   <= k_next;
                            ovf_q <= ovf_q | carry;
                        end else begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i    = i_q;
    assign bus.n    = n_q;
    assign bus.k    = k_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_loop_accum_engine.sv
// Drives a wrapping and a saturating engine in lockstep and checks both against
// an arithmetic model of the loop, plus directed end-of-run values.
module tb_loop_accum_engine;

    localparam int W     = 11;
    localparam int LANES = 2;
    localparam int MAXV  = 1 << W;

    logic clk;
    logic rst;

    loop_accum_engine_if #(.W(W), .LANES(LANES)) bw ();
    loop_accum_engine_if #(.W(W), .LANES(LANES)) bs ();

    loop_accum_engine #(.W(W), .LANES(LANES), .N_INIT(40), .SAT(0), .AUTO_RUN(1))
        dut_w (.clk(clk), .rst(rst), .bus(bw.slave));
    loop_accum_engine #(.W(W), .LANES(LANES), .N_INIT(40), .SAT(1), .AUTO_RUN(1))
        dut_s (.clk(clk), .rst(rst), .bus(bs.slave));

    assign bs.start  = bw.start;
    assign bs.abort  = bw.abort;
    assign bs.hold   = bw.hold;
    assign bs.sel    = bw.sel;
    assign bs.cfg_n  = bw.cfg_n;
    assign bs.step_a = bw.step_a;
    assign bs.step_b = bw.step_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: 0 = idle, 1 = running, 2 = finished
    int m_st, m_i, m_n;
    bit m_armed;
    int m_kw[LANES];
    int m_ks[LANES];
    logic [LANES-1:0] m_ovw, m_ovs;
    int sa[LANES];
    int sb[LANES];

    function automatic logic [LANES*W-1:0] pack(input int v[LANES]);
        logic [LANES*W-1:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++) r[j*W +: W] = W'(v[j]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 1; m_i = 0; m_n = 40; m_armed = 0;
        m_ovw = '0; m_ovs = '0;
        for (int j = 0; j < LANES; j++) begin m_kw[j] = 0; m_ks[j] = 0; end
    endtask

    task automatic model_load();
        m_n = int'(bw.cfg_n); m_i = 0; m_st = 1;
        m_ovw = '0; m_ovs = '0;
        for (int j = 0; j < LANES; j++) begin m_kw[j] = 0; m_ks[j] = 0; end
    endtask

    task automatic model_edge();
        int s, sum;
        if (!m_armed) begin
            m_armed = 1;
        end else if (m_st != 1) begin
            if (bw.start) model_load();
        end else if (bw.abort) begin
            m_st = 0;
        end else if (!bw.hold) begin
            if (m_i < m_n) begin
                m_i++;
                for (int j = 0; j < LANES; j++) begin
                    s = bw.sel ? sb[j] : sa[j];
                    sum = m_kw[j] + s;
                    if (sum >= MAXV) m_ovw[j] = 1'b1;
                    m_kw[j] = sum % MAXV;
                    sum = m_ks[j] + s;
                    if (sum > MAXV - 1) begin m_ks[j] = MAXV - 1; m_ovs[j] = 1'b1; end
                    else m_ks[j] = sum;
                end
            end else begin
                m_st = 2;
            end
        end
    endtask

    task automatic applyStimulus(input bit st, input bit ab, input bit hd, input bit sl);
        bw.start  = st;
        bw.abort  = ab;
        bw.hold   = hd;
        bw.sel    = sl;
        bw.step_a = pack(sa);
        bw.step_b = pack(sb);
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".w.i"},    32'(bw.i),    32'(m_i));
        chk({tag, ".w.n"},    32'(bw.n),    32'(m_n));
        chk({tag, ".w.k"},    32'(bw.k),    32'(pack(m_kw)));
        chk({tag, ".w.busy"}, 32'(bw.busy), 32'(m_st == 1));
        chk({tag, ".w.done"}, 32'(bw.done), 32'(m_st == 2));
        chk({tag, ".w.ovf"},  32'(bw.ovf),  32'(m_ovw));
        chk({tag, ".s.i"},    32'(bs.i),    32'(m_i));
        chk({tag, ".s.n"},    32'(bs.n),    32'(m_n));
        chk({tag, ".s.k"},    32'(bs.k),    32'(pack(m_ks)));
        chk({tag, ".s.busy"}, 32'(bs.busy), 32'(m_st == 1));
        chk({tag, ".s.done"}, 32'(bs.done), 32'(m_st == 2));
        chk({tag, ".s.ovf"},  32'(bs.ovf),  32'(m_ovs));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic run_to_done(input string tag, input int limit, output int cycles);
        cycles = 0;
        while (!bw.done && cycles < limit) begin
            tick(tag);
            cycles++;
        end
        chk({tag, ".bounded"}, 32'(cycles < limit), 32'd1);
    endtask

    initial begin
        int cyc;
        int runs;
        rst = 1'b1;
        sa[0] = 50; sa[1] = 1; sb[0] = 0; sb[1] = 0;
        bw.cfg_n = '0;
        applyStimulus(0, 0, 0, 0);
        #1 rst = 1'b0;
        model_reset();
        #2 checkOutput("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;

        // default auto-run: 40 iterations of steps 50 and 1
        tick("t1_arm");
        for (int c = 0; c < 40; c++) tick("t1_run");
        chk("t1_i40", 32'(bw.i), 32'd40);
        chk("t1_k0", 32'(bw.k[0 +: W]), 32'd2000);
        chk("t1_k1", 32'(bw.k[W +: W]), 32'd40);
        chk("t1_not_done_yet", 32'(bw.done), 32'd0);
        tick("t1_fin");
        chk("t1_done", 32'(bw.done), 32'd1);
        chk("t1_ovf", 32'(bw.ovf), 32'd0);
        tick("t1_stay");
        chk("t1_done_stays", 32'(bw.done), 32'd1);

        // wrap versus saturate over 45 iterations
        $display("[TB] wrap/saturate run");
        bw.cfg_n = 11'd45;
        applyStimulus(1, 0, 0, 0);
        tick("t2_load");
        applyStimulus(0, 0, 0, 0);
        run_to_done("t2", 100, cyc);
        chk("t2_kw", 32'(bw.k[0 +: W]), 32'd202);
        chk("t2_ks", 32'(bs.k[0 +: W]), 32'd2047);
        chk("t2_ovw", 32'(bw.ovf), 32'd1);
        chk("t2_ovs", 32'(bs.ovf), 32'd1);
        chk("t2_is", 32'(bs.i), 32'd45);

        // alternating step source with a three-cycle hold mid-run
        sa[0] = 3; sa[1] = 1; sb[0] = 7; sb[1] = 2;
        bw.cfg_n = 11'd10;
        applyStimulus(1, 0, 0, 0);
        tick("t4_load");
        cyc = 0;
        while (!bw.done && cyc < 100) begin
            applyStimulus(0, 0, (cyc >= 4 && cyc < 7), m_i[0]);
            tick("t4_run");
            cyc++;
        end
        chk("t4_latency", 32'(cyc), 32'd14);
        chk("t4_k0", 32'(bw.k[0 +: W]), 32'd50);
        chk("t4_k1", 32'(bw.k[W +: W]), 32'd15);
        chk("t4_i", 32'(bw.i), 32'd10);

        // abort, start+abort, zero bound
        applyStimulus(0, 0, 0, 0);
        bw.cfg_n = 11'd20;
        applyStimulus(1, 0, 0, 0);
        tick("t5_load");
        applyStimulus(0, 0, 0, 0);
        cyc = 0;
        while (m_i < 5 && cyc < 50) begin tick("t5_run"); cyc++; end
        applyStimulus(0, 1, 0, 0);
        tick("t5_abort");
        chk("t5_i_held", 32'(bw.i), 32'd5);
        chk("t5_busy", 32'(bw.busy), 32'd0);
        applyStimulus(0, 0, 0, 0);
        tick("t5_idle");
        applyStimulus(1, 0, 0, 0);
        tick("t5_restart");
        tick("t5_run2");
        applyStimulus(1, 1, 0, 0);
        tick("t5_start_abort");
        chk("t5_sa_busy", 32'(bw.busy), 32'd0);
        bw.cfg_n = 11'd0;
        applyStimulus(1, 0, 0, 0);
        tick("t5_zero_load");
        applyStimulus(0, 0, 0, 0);
        tick("t5_zero_fin");
        chk("t5_zero_done", 32'(bw.done), 32'd1);
        chk("t5_zero_k", 32'(bw.k), 32'd0);

        // randomized runs with random steps, sources, holds and rare aborts
        $display("[TB] randomized runs");
        for (runs = 0; runs < 8; runs++) begin
            for (int j = 0; j < LANES; j++) begin
                sa[j] = int'($urandom_range(0, MAXV - 1));
                sb[j] = int'($urandom_range(0, MAXV - 1));
            end
            bw.cfg_n = W'($urandom_range(0, 60));
            applyStimulus(1, 0, 0, 0);
            tick("rnd_load");
            cyc = 0;
            while (m_st == 1 && cyc < 300) begin
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
                              $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
                tick("rnd_run");
                cyc++;
            end
            chk("rnd_bounded", 32'(cyc < 300), 32'd1);
        end

        // asynchronous reset mid-run, then one swallowed edge
        sa[0] = 50; sa[1] = 1;
        bw.cfg_n = 11'd30;
        applyStimulus(1, 0, 0, 0);
        tick("t6_load");
        applyStimulus(0, 0, 0, 0);
        for (int c = 0; c < 6; c++) tick("t6_run");
        #2 rst = 1'b0;
        model_reset();
        #1 checkOutput("t6_async");
        chk("t6_n", 32'(bw.n), 32'd40);
        #1 rst = 1'b1;
        tick("t6_arm");
        chk("t6_no_update", 32'(bw.i), 32'd0);
        tick("t6_resume");
        chk("t6_resumed", 32'(bw.i), 32'd1);
        chk("t6_k0", 32'(bw.k[0 +: W]), 32'd50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
